edge_detect_filt: RTL

- Parametrised successor to the basic two-flop edge detector.
- Each of WIDTH asynchronous input channels is synchronised, then glitch-filtered with a per-channel stability counter.
- Emits one-cycle rise and fall pulses and the filtered level.
- Per-channel mode selects which edges set a sticky event flag; flags are cleared by write-1-to-clear, and their OR drives an interrupt line toward the USB driver control logic.

---
 rtl/edge_detect_filt.sv | 79 +++++++
 1 files changed

// File: rtl/edge_detect_filt.sv
// edge_detect_filt: per-channel synchroniser, stability filter, edge pulses and sticky W1C event flags with irq.
module edge_detect_filt #(
    parameter int               WIDTH       = 5,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_CNT    = 4,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     signal,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     pos,
    output logic [WIDTH-1:0]     neg,
    output logic [WIDTH-1:0]     flag,
    output logic                 irq
);
    localparam int CW = (FILT_CNT > 1) ? $clog2(FILT_CNT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] set;
    logic [CW-1:0]    cnt [WIDTH];

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VAL;
        end else begin
            sync_q[0] <= signal;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // any return to the current level restarts the qualification count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= INIT_VAL;
            for (int c = 0; c < WIDTH; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (sync_out[c] == level[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == CNT_LAST) begin
                    level[c] <= sync_out[c];
                    cnt[c]   <= '0;
                end else begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        set = '0;
        for (int c = 0; c < WIDTH; c++)
            set[c] = (pos[c] & mode[2*c]) | (neg[c] & mode[2*c+1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= INIT_VAL;
            pos     <= '0;
            neg     <= '0;
            flag    <= '0;
        end else begin
            level_d <= level;
            pos     <= level & ~level_d;
            neg     <= ~level & level_d;
            flag    <= set | (flag & ~clr);
        end
    end

    assign irq = |flag;
endmodule
